// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. It merges the
// load-use hazard, taken-branch redirects and the instruction/data memory
// ready handshakes. From these it drives per-stage register enables and
// flush (bubble) controls. A wait-state FSM with timeout and saturating
// stall/flush performance counters complete the block.
//
// Parameters:
//   MAX_WAIT  consecutive cycles of one wait rule before timeout (2..255)
//   CNT_W     width of the performance counters
// Ports:
//   clk, arst_n                           clock, async active-low reset
//   load_use_hazard, branch_taken         hazard / redirect requests
//   dmem_req, dmem_ready, imem_ready      memory handshakes
//   pc_en .. mem_wb_en                    pipeline register load enables
//   if_id_flush .. mem_wb_flush           NOP-load controls (override *_en)
//   wait_timeout                          sticky timeout flag
//   state                                 RUN=0, DWAIT=1, IWAIT=2, HALT=3
//   stall_cycles, flush_events            saturating performance counters
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             wait_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    R_DMEM     = 3'd0,
    R_BRANCH   = 3'd1,
    R_LOAD_USE = 3'd2,
    R_IMEM     = 3'd3,
    R_NONE     = 3'd4
  } rule_t;

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [7:0]       wait_cnt_r;
  logic             wait_timeout_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_events_r;

  rule_t            rule_s;
  logic             is_wait_s;
  logic             same_wait_s;
  logic [7:0]       wait_next_s;
  logic             timeout_hit_s;

  // Priority selection of the active rule; dmem wait first so a pending
  // branch stays frozen in EX/MEM until the data access completes.
  always_comb begin
    rule_s = R_NONE;
    if (dmem_req && !dmem_ready) begin
      rule_s = R_DMEM;
    end else if (branch_taken) begin
      rule_s = R_BRANCH;
    end else if (load_use_hazard) begin
      rule_s = R_LOAD_USE;
    end else if (!imem_ready) begin
      rule_s = R_IMEM;
    end else begin
      rule_s = R_NONE;
    end
  end

  // Consecutive-wait tracking: the current state tells which wait rule ran
  // last cycle, so switching between dmem and imem wait restarts the count
  // with this cycle as the first one.
  always_comb begin
    is_wait_s   = (rule_s == R_DMEM) || (rule_s == R_IMEM);
    same_wait_s = ((rule_s == R_DMEM) && (state_r == ST_DWAIT)) ||
                  ((rule_s == R_IMEM) && (state_r == ST_IWAIT));
    if (same_wait_s) begin
      wait_next_s = wait_cnt_r + 8'd1;
    end else begin
      wait_next_s = 8'd1;
    end
    timeout_hit_s = is_wait_s && (wait_next_s == MAX_WAIT_C);
  end

  // Enable/flush decode; everything forced low in reset and in HALT.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!arst_n || (state_r == ST_HALT)) begin
      pc_en = 1'b0;
    end else begin
      case (rule_s)
        R_DMEM: begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
        end
        R_BRANCH: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end
        R_LOAD_USE: begin
          {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
          id_ex_flush = 1'b1;
        end
        R_IMEM: begin
          {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
          if_id_flush = 1'b1;
        end
        default: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      endcase
    end
  end

  // FSM, wait counter, timeout flag and saturating performance counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r        <= ST_RUN;
      wait_cnt_r     <= 8'd0;
      wait_timeout_r <= 1'b0;
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_events_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_HALT) begin
      case (rule_s)
        R_DMEM, R_IMEM: begin
          wait_cnt_r <= wait_next_s;
          if (timeout_hit_s) begin
            state_r        <= ST_HALT;
            wait_timeout_r <= 1'b1;
          end else if (rule_s == R_DMEM) begin
            state_r <= ST_DWAIT;
          end else begin
            state_r <= ST_IWAIT;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= 8'd0;
        end
      endcase
      if ((rule_s != R_BRANCH) && (rule_s != R_NONE) &&
          (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end
      if ((rule_s == R_BRANCH) && (flush_events_r != CNT_MAX)) begin
        flush_events_r <= flush_events_r + CNT_ONE;
      end
    end
  end

  assign state        = state_r;
  assign wait_timeout = wait_timeout_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. The main instance uses
// MAX_WAIT=4 for the timeout scenarios; a second instance (MAX_WAIT=64,
// CNT_W=4) shares the same stimulus and is used for counter saturation.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic load_use_hazard = 1'b0;
  logic branch_taken = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_ready = 1'b0;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic wait_timeout;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_events;

  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
  logic s_wait_timeout;
  logic [1:0] s_state;
  logic [3:0] s_stall_cycles, s_flush_events;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .load_use_hazard(load_use_hazard),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .wait_timeout(wait_timeout), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_stall_controller #(.MAX_WAIT(64), .CNT_W(4)) dut_sat (
    .clk(clk), .arst_n(arst_n), .load_use_hazard(load_use_hazard),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
    .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
    .wait_timeout(s_wait_timeout), .state(s_state),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  wire [4:0] en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [3:0] fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then let the decode settle.
  task automatic drive(input logic lu, input logic br, input logic dreq,
                       input logic drdy, input logic irdy);
    load_use_hazard = lu;
    branch_taken    = br;
    dmem_req        = dreq;
    dmem_ready      = drdy;
    imem_ready      = irdy;
    #3;
  endtask

  task automatic comb(input string tag, input logic [4:0] en_e, input logic [3:0] fl_e);
    chk({tag, "_en"}, 32'(en_v), 32'(en_e));
    chk({tag, "_fl"}, 32'(fl_v), 32'(fl_e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with busy inputs: everything held at zero.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    comb("rst", 5'b00000, 4'b0000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_events), 32'd0);
    chk("rst_to", 32'(wait_timeout), 32'd0);
    tick();
    arst_n = 1'b1;

    // Default flow.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    comb("run", 5'b11111, 4'b0000);
    tick();
    chk("run_state", 32'(state), 32'd0);

    // Single load-use bubble.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    comb("lu", 5'b00111, 4'b0100);
    tick();
    chk("lu_state", 32'(state), 32'd0);
    chk("lu_stall", 32'(stall_cycles), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    comb("lu_after", 5'b11111, 4'b0000);
    tick();
    chk("lu_after_stall", 32'(stall_cycles), 32'd1);

    // Dmem wait for three cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      comb("dw", 5'b00001, 4'b0001);
      tick();
      chk("dw_state", 32'(state), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    comb("dw_done", 5'b11111, 4'b0000);
    tick();
    chk("dw_done_state", 32'(state), 32'd0);
    chk("dw_done_stall", 32'(stall_cycles), 32'd4);
    chk("dw_done_to", 32'(wait_timeout), 32'd0);

    // Branch beats load-use and missing fetch.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    comb("br", 5'b11111, 4'b1110);
    tick();
    chk("br_state", 32'(state), 32'd0);
    chk("br_flush", 32'(flush_events), 32'd1);
    chk("br_stall", 32'(stall_cycles), 32'd4);

    // Branch during dmem wait: freeze first, redirect when ready rises.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    comb("brdw", 5'b00001, 4'b0001);
    tick();
    chk("brdw_state", 32'(state), 32'd1);
    chk("brdw_flush", 32'(flush_events), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    comb("brdw_go", 5'b11111, 4'b1110);
    tick();
    chk("brdw_go_state", 32'(state), 32'd0);
    chk("brdw_go_flush", 32'(flush_events), 32'd2);
    chk("brdw_go_stall", 32'(stall_cycles), 32'd5);

    // Reset asserted in the second cycle of a dmem wait.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    comb("rdw_pre", 5'b00001, 4'b0001);
    arst_n = 1'b0;
    #1;
    comb("rdw", 5'b00000, 4'b0000);
    chk("rdw_state", 32'(state), 32'd0);
    chk("rdw_stall", 32'(stall_cycles), 32'd0);
    chk("rdw_flush", 32'(flush_events), 32'd0);
    tick();
    arst_n = 1'b1;

    // After release the wait count starts fresh: three waits stay below 4.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    comb("rel", 5'b11111, 4'b0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    chk("rel_dw_state", 32'(state), 32'd1);
    chk("rel_dw_to", 32'(wait_timeout), 32'd0);
    chk("rel_dw_stall", 32'(stall_cycles), 32'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("edge_state", 32'(state), 32'd0);
    chk("edge_to", 32'(wait_timeout), 32'd0);

    // Imem wait timeout after 4 wait cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      comb("iw", 5'b01111, 4'b1000);
      tick();
      chk("iw_state", 32'(state), 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("to_state", 32'(state), 32'd3);
    chk("to_flag", 32'(wait_timeout), 32'd1);
    chk("to_stall", 32'(stall_cycles), 32'd7);
    comb("to", 5'b00000, 4'b0000);

    // HALT ignores everything.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      comb("halt", 5'b00000, 4'b0000);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    comb("halt_idle", 5'b00000, 4'b0000);
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_stall", 32'(stall_cycles), 32'd7);
    chk("halt_flush", 32'(flush_events), 32'd0);
    chk("halt_to", 32'(wait_timeout), 32'd1);

    // Only reset leaves HALT.
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rec_state", 32'(state), 32'd0);
    chk("rec_to", 32'(wait_timeout), 32'd0);
    comb("rec", 5'b11111, 4'b0000);
    tick();

    // Saturation: 20 imem waits on the CNT_W=4 / MAX_WAIT=64 instance.
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 13) chk("sat_14", 32'(s_stall_cycles), 32'd14);
    end
    chk("sat_stall", 32'(s_stall_cycles), 32'd15);
    chk("sat_state", 32'(s_state), 32'd2);
    chk("sat_to", 32'(s_wait_timeout), 32'd0);
    chk("sat_main_state", 32'(state), 32'd3);
    chk("sat_main_stall", 32'(stall_cycles), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use indication from hazard detection, taken-branch redirects from EX/MEM, and ready handshakes from instruction and data memory. From these it drives per-stage register enables and bubble/flush controls, and runs a wait-state FSM with timeout. It also keeps saturating stall/flush performance counters and sits beside the pipeline registers in the CPU top level.

## Interface
- `MAX_WAIT`, 64: consecutive memory-wait cycles before timeout; valid range 2..255.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  rising-edge clock
- `arst_n`  in  1  asynchronous active-low reset
- `load_use_hazard`  in  1  ID/EX load whose rd matches IF/ID rs1/rs2
- `branch_taken`  in  1  taken branch/jump resolved in EX/MEM; PC target valid
- `dmem_req`  in  1  EX/MEM instruction accesses data memory (read or write)
- `dmem_ready`  in  1  data memory completes access this cycle
- `imem_ready`  in  1  instruction memory returns fetch this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register load enables
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  load NOP/zero controls into the register; a flush overrides `*_en`
- `wait_timeout`  out  1  sticky timeout flag
- `state`  out  2  FSM state: RUN=0, DWAIT=1, IWAIT=2, HALT=3
- `stall_cycles`  out  CNT_W  cycles with `pc_en`=0, excluding HALT; saturating
- `flush_events`  out  CNT_W  branch-flush cycles; saturating

## Operation
- Enables and flushes are combinational from `state` and the inputs. `state`, the wait counter, `wait_timeout` and the perf counters are registered.
- In RUN, DWAIT or IWAIT, the first matching rule applies each cycle:
  1. **dmem wait** (`dmem_req` & !`dmem_ready`): `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `mem_wb_flush` = 1. Next state DWAIT.
  2. **branch redirect** (`branch_taken`): all enables 1; `if_id_flush`, `id_ex_flush`, `ex_mem_flush` = 1; `flush_events` +1. Next state RUN, even if `imem_ready` = 0.
  3. **load-use stall** (`load_use_hazard`): `pc_en` = `if_id_en` = 0; `id_ex_flush` = 1; other enables 1. Next state RUN.
  4. **imem wait** (!`imem_ready`): `pc_en` = 0; `if_id_flush` = 1; other enables 1. Next state IWAIT.
  5. **default**: all enables 1, no flush. Next state RUN.
- Simultaneous `branch_taken` and dmem wait:
  - Rule 1 wins and EX/MEM is frozen, so `branch_taken` stays asserted.
  - The redirect executes on the cycle `dmem_ready` rises.
- Wait counter (8 bit):
  - Increments each cycle the rule selected is 1 or 4.
  - Clears on any cycle selecting rule 2, 3 or 5.
  - Also clears when the selected rule changes between 1 and 4.
- Timeout: when the same wait rule is selected for `MAX_WAIT` consecutive cycles, the next state is HALT and `wait_timeout` is set.
- HALT:
  - All enables 0, all flushes 0.
  - Inputs are ignored; counters are frozen.
  - Exit only by reset.
- Counters saturate at all-ones and never wrap.

## Timing
- While `arst_n` = 0, and on its release:
  - `state` = RUN; wait counter = 0; `wait_timeout` = 0; `stall_cycles` = `flush_events` = 0.
  - All enables and all flushes forced to 0, regardless of inputs.
- Reset asserted mid-DWAIT/IWAIT takes effect immediately (asynchronous). No residual wait count survives.
- Decision-to-effect: zero cycles combinationally; the pipeline registers act on the same rising edge.
- Load-use produces exactly one bubble, provided `load_use_hazard` drops after the load advances.
- Timeout edge case: if `dmem_ready` rises in the `MAX_WAIT`-th wait cycle, no timeout occurs and `state` returns to RUN.
- `stall_cycles` counts rules 1, 3 and 4. `flush_events` counts rule 2. Both register on the following edge.

## Test plan
- Load-use: `load_use_hazard` = 1 for one cycle, `imem_ready` = 1 → `pc_en` = `if_id_en` = 0 and `id_ex_flush` = 1 for that cycle only; `stall_cycles` = 1; `state` stays RUN.
- Dmem wait: `dmem_req` = 1, `dmem_ready` low for 3 cycles then high → front four enables 0 and `mem_wb_flush` = 1 for 3 cycles; `state` = DWAIT; then RUN with all enables 1; `stall_cycles` = 3.
- Priority: `branch_taken` and `load_use_hazard` asserted in the same cycle with `imem_ready` = 0 → three flushes, `pc_en` = 1, `flush_events` = 1, `stall_cycles` unchanged. Then `branch_taken` with `dmem_req` & !`dmem_ready` → freeze first; the flush fires on the `dmem_ready` cycle.
- Timeout with `MAX_WAIT` = 4: `imem_ready` = 0 held → after 4 IWAIT cycles `state` = HALT, `wait_timeout` = 1, all outputs 0. Further inputs change nothing. Only `arst_n` pulse recovers.
- Reset mid-DWAIT: drop `arst_n` in cycle 2 of a dmem wait → all outputs 0 immediately. After release with `dmem_ready` = 1, the wait counter restarts from 0.
- Saturation with `CNT_W` = 4: 20 consecutive imem-wait cycles (`MAX_WAIT` = 64) → `stall_cycles` holds at 15.
